// File: rtl/tag_lookup_ctrl_pkg.sv
// Shared types and defaults for the tag RAM lookup/fill controller.
// The state encoding is fixed because RAM-side debug tooling decodes it.
package tag_lookup_ctrl_pkg;

   localparam int DEPTH_DEF = 32;
   localparam int TAG_W_DEF = 20;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INV   = 3'd1,
      ST_READ  = 3'd2,
      ST_CMP   = 3'd3,
      ST_FILL  = 3'd4,
      ST_WRITE = 3'd5
   } state_e;

endpackage

// File: rtl/tag_lookup_ctrl.sv
// Reader/filler FSM for a single-cycle-invalidate tag RAM: lookup, miss fill and flush-all.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting; starts a pending/requested flush first, else a lookup
// ST_INV   | one cycle for the RAM to clear all valid bits
// ST_READ  | RAM read issued, data lands at the end of this cycle
// ST_CMP   | compare returned tag+valid against the latched tag
// ST_FILL  | fill request outstanding, waiting for i_fill_ack
// ST_WRITE | returned tag written, acknowledge the lookup
module tag_lookup_ctrl
   import tag_lookup_ctrl_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   parameter  int TAG_W = TAG_W_DEF,
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_req,
   input  logic [IW-1:0]    i_index,
   input  logic [TAG_W-1:0] i_tag,
   input  logic             i_inv_req,
   output logic             o_ack,
   output logic             o_hit,
   output logic             o_err,
   output logic             o_busy,
   output logic             o_fill_req,
   output logic [IW-1:0]    o_fill_index,
   input  logic             i_fill_ack,
   input  logic [TAG_W-1:0] i_fill_tag,
   input  logic             i_fill_err,
   output logic             o_ram_ren,
   output logic [IW-1:0]    o_ram_raddr,
   output logic             o_ram_wen,
   output logic [IW-1:0]    o_ram_waddr,
   output logic [TAG_W-1:0] o_ram_wdata,
   output logic             o_ram_refresh,
   output logic             o_ram_inv,
   input  logic [TAG_W-1:0] i_ram_rdata,
   input  logic             i_ram_rdav
);

   state_e             state_q, state_d;
   logic               pend_q, pend_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               ack_q, ack_d;
   logic               hit_q, hit_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               fill_req_q, fill_req_d;
   logic               ren_q, ren_d;
   logic               wen_q, wen_d;
   logic [IW-1:0]      waddr_q, waddr_d;
   logic [TAG_W-1:0]   wdata_q, wdata_d;
   logic               inv_q, inv_d;

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      idx_d      = idx_q;
      tag_d      = tag_q;
      ack_d      = 1'b0;
      hit_d      = 1'b0;
      err_d      = 1'b0;
      fill_req_d = fill_req_q;
      ren_d      = 1'b0;
      wen_d      = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      inv_d      = 1'b0;

      // A flush seen mid-lookup is deferred so the lookup completes untouched.
      if (state_q != ST_IDLE && i_inv_req) begin
         pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (pend_q || i_inv_req) begin
               inv_d   = 1'b1;
               pend_d  = 1'b0;
               state_d = ST_INV;
            end else if (i_req) begin
               idx_d   = i_index;
               tag_d   = i_tag;
               ren_d   = 1'b1;
               state_d = ST_READ;
            end
         end
         ST_INV:  state_d = ST_IDLE;
         ST_READ: state_d = ST_CMP;
         ST_CMP: begin
            if (i_ram_rdav && (i_ram_rdata == tag_q)) begin
               ack_d   = 1'b1;
               hit_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               fill_req_d = 1'b1;
               state_d    = ST_FILL;
            end
         end
         ST_FILL: begin
            if (i_fill_ack) begin
               fill_req_d = 1'b0;
               if (i_fill_err) begin
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  wen_d   = 1'b1;
                  waddr_d = idx_q;
                  wdata_d = i_fill_tag;
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            ack_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered from next-state so o_busy matches the current state/flag.
      busy_d = (state_d != ST_IDLE) || pend_d;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_IDLE;
         pend_q     <= 1'b0;
         idx_q      <= '0;
         tag_q      <= '0;
         ack_q      <= 1'b0;
         hit_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         fill_req_q <= 1'b0;
         ren_q      <= 1'b0;
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         inv_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         idx_q      <= idx_d;
         tag_q      <= tag_d;
         ack_q      <= ack_d;
         hit_q      <= hit_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         fill_req_q <= fill_req_d;
         ren_q      <= ren_d;
         wen_q      <= wen_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         inv_q      <= inv_d;
      end
   end

   // The RAM samples its valid bit every cycle, so raddr must hold the index through CMP.
   assign o_ram_raddr   = idx_q;
   assign o_fill_index  = idx_q;
   assign o_ack         = ack_q;
   assign o_hit         = hit_q;
   assign o_err         = err_q;
   assign o_busy        = busy_q;
   assign o_fill_req    = fill_req_q;
   assign o_ram_ren     = ren_q;
   assign o_ram_wen     = wen_q;
   assign o_ram_waddr   = waddr_q;
   assign o_ram_wdata   = wdata_q;
   assign o_ram_inv     = inv_q;
   assign o_ram_refresh = 1'b0;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Scoreboarded bench for tag_lookup_ctrl with a behavioural tag RAM and a per-index tag model.
module tb_tag_lookup_ctrl;

   localparam int DEPTH = 32;
   localparam int TAG_W = 20;
   localparam int IW    = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_req = 1'b0;
   logic [IW-1:0]    i_index = '0;
   logic [TAG_W-1:0] i_tag = '0;
   logic             i_inv_req = 1'b0;
   logic             i_fill_ack = 1'b0;
   logic [TAG_W-1:0] i_fill_tag = '0;
   logic             i_fill_err = 1'b0;
   logic             o_ack, o_hit, o_err, o_busy, o_fill_req;
   logic [IW-1:0]    o_fill_index, o_ram_raddr, o_ram_waddr;
   logic             o_ram_ren, o_ram_wen, o_ram_refresh, o_ram_inv;
   logic [TAG_W-1:0] o_ram_wdata;
   bit   [TAG_W-1:0] ram_rdata;
   bit               ram_rdav;

   always #5 clk = ~clk;

   tag_lookup_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_req(i_req), .i_index(i_index), .i_tag(i_tag),
      .i_inv_req(i_inv_req), .o_ack(o_ack), .o_hit(o_hit), .o_err(o_err), .o_busy(o_busy),
      .o_fill_req(o_fill_req), .o_fill_index(o_fill_index), .i_fill_ack(i_fill_ack),
      .i_fill_tag(i_fill_tag), .i_fill_err(i_fill_err), .o_ram_ren(o_ram_ren),
      .o_ram_raddr(o_ram_raddr), .o_ram_wen(o_ram_wen), .o_ram_waddr(o_ram_waddr),
      .o_ram_wdata(o_ram_wdata), .o_ram_refresh(o_ram_refresh), .o_ram_inv(o_ram_inv),
      .i_ram_rdata(ram_rdata), .i_ram_rdav(ram_rdav)
   );

   // Tag RAM: one-cycle read latency, valid bit read every cycle, flush clears all valids.
   bit [TAG_W-1:0] ram_tag [DEPTH];
   bit             ram_v   [DEPTH];
   always @(posedge clk) begin
      ram_rdav <= ram_v[o_ram_raddr];
      if (o_ram_ren) ram_rdata <= ram_tag[o_ram_raddr];
      if (o_ram_inv) begin
         for (int i = 0; i < DEPTH; i++) ram_v[i] <= 1'b0;
      end
      if (o_ram_wen) begin
         ram_tag[o_ram_waddr] <= o_ram_wdata;
         ram_v[o_ram_waddr]   <= 1'b1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed { logic hit; logic err; } exp_t;
   exp_t exp_q[$];

   // Reference: what each index currently holds, as seen by a lookup.
   bit               mv [DEPTH];
   logic [TAG_W-1:0] mt [DEPTH];

   logic [43:0] out_vec;
   assign out_vec = {o_ack, o_hit, o_err, o_busy, o_fill_req, o_fill_index, o_ram_ren,
                     o_ram_raddr, o_ram_wen, o_ram_waddr, o_ram_wdata, o_ram_refresh, o_ram_inv};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (o_ack) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL ack_unexpected: got o_ack=1, expected no pending lookup");
            end else begin
               e = exp_q.pop_front();
               check("ack_hit", 64'(o_hit), 64'(e.hit));
               check("ack_err", 64'(o_err), 64'(e.err));
               check("ram_refresh", 64'(o_ram_refresh), 64'd0);
            end
         end
         if (o_ram_ren || o_ram_wen) check("ren_wen_exclusive", 64'(o_ram_ren & o_ram_wen), 64'd0);
      end
   end

   task automatic lookup(input logic [IW-1:0] idx, input logic [TAG_W-1:0] tag, input bit ferr,
                         input logic [TAG_W-1:0] ftag, input bit inv_mid, input bit inv_same);
      bit   exp_hit, saw_inv, saw_fill, acked_fill, inv_raised, done;
      exp_t e;
      int   dly, t0;
      saw_inv = 0; saw_fill = 0; acked_fill = 0; inv_raised = 0; done = 0; dly = 0;
      @(negedge clk);
      if (inv_same) clear_model();
      exp_hit = mv[idx] && (mt[idx] == tag);
      e.hit = exp_hit;
      e.err = !exp_hit && ferr;
      exp_q.push_back(e);
      i_req = 1'b1; i_index = idx; i_tag = tag; i_inv_req = inv_same;
      t0 = cyc;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         i_inv_req  = 1'b0;
         i_fill_ack = 1'b0;
         if (k == 0) check("busy_after_issue", 64'(o_busy), 64'd1);
         if (o_ram_inv) saw_inv = 1;
         if (o_ram_wen) begin
            check("ram_waddr", 64'(o_ram_waddr), 64'(idx));
            check("ram_wdata", 64'(o_ram_wdata), 64'(ftag));
         end
         if (o_fill_req && !saw_fill) begin
            saw_fill = 1;
            check("fill_index", 64'(o_fill_index), 64'(idx));
            dly = $urandom_range(0, 3);
            if (inv_mid) begin
               i_inv_req  = 1'b1;
               inv_raised = 1;
            end
         end
         if (o_fill_req && !acked_fill) begin
            if (dly == 0) begin
               i_fill_ack = 1'b1; i_fill_tag = ftag; i_fill_err = ferr;
               acked_fill = 1;
            end else dly--;
         end
         if (o_ack) begin
            done  = 1;
            i_req = 1'b0;
            check("fill_req_seen", 64'(saw_fill), 64'(!exp_hit));
            if (inv_same) begin
               check("inv_before_ack", 64'(saw_inv), 64'd1);
               check("inv_ack_latency_ge3", 64'((cyc - t0) >= 3), 64'd1);
            end else if (exp_hit) begin
               check("hit_latency", 64'(cyc - t0), 64'd3);
            end
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL ack_timeout: got no o_ack in 200 cycles, expected one (idx=%0d)", idx);
         i_req = 1'b0;
      end
      if (!exp_hit && !ferr) begin
         mv[idx] = 1'b1;
         mt[idx] = ftag;
      end
      if (inv_raised) begin
         saw_inv = 0;
         repeat (4) begin
            @(negedge clk);
            if (o_ram_inv) saw_inv = 1;
         end
         check("flush_after_fill", 64'(saw_inv), 64'd1);
         clear_model();
      end
   endtask

   task automatic reset_mid_fill(input logic [IW-1:0] idx, input logic [TAG_W-1:0] tag);
      bit   got_fill, any;
      got_fill = 0; any = 0;
      @(negedge clk);
      i_req = 1'b1; i_index = idx; i_tag = tag;
      for (int k = 0; k < 20 && !got_fill; k++) begin
         @(negedge clk);
         if (o_fill_req) got_fill = 1;
      end
      check("reset_test_reached_fill", 64'(got_fill), 64'd1);
      #2 rst_n = 1'b0;
      #1 check("reset_async_outputs", 64'(out_vec), 64'd0);
      i_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      i_fill_ack = 1'b1; i_fill_tag = tag; i_fill_err = 1'b0;
      @(negedge clk);
      i_fill_ack = 1'b0;
      repeat (4) begin
         if (o_ack || o_fill_req || o_ram_wen || o_busy) any = 1;
         @(negedge clk);
      end
      check("late_fill_ack_ignored", 64'(any), 64'd0);
   endtask

   initial begin
      logic [IW-1:0]    r_idx;
      logic [TAG_W-1:0] r_tag, r_ftag;
      clear_model();
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'(out_vec), 64'd0);
      rst_n = 1'b1;

      lookup(5'd5, 20'h0ABCD, 1'b0, 20'h0ABCD, 1'b0, 1'b0);   // cold miss, fill
      lookup(5'd5, 20'h0ABCD, 1'b0, 20'h0ABCD, 1'b0, 1'b0);   // hit
      lookup(5'd5, 20'h01234, 1'b1, 20'h01234, 1'b0, 1'b0);   // alias, fill error
      lookup(5'd5, 20'h0ABCD, 1'b0, 20'h0ABCD, 1'b0, 1'b0);   // still hits
      lookup(5'd7, 20'h00777, 1'b0, 20'h00777, 1'b1, 1'b0);   // flush during fill
      lookup(5'd5, 20'h0ABCD, 1'b0, 20'h0ABCD, 1'b0, 1'b0);   // misses after flush
      lookup(5'd9, 20'h00099, 1'b0, 20'h00099, 1'b0, 1'b1);   // flush + req same cycle
      reset_mid_fill(5'd12, 20'h00C0C);
      lookup(5'd12, 20'h00C0C, 1'b0, 20'h00C0C, 1'b0, 1'b0);
      lookup(5'd12, 20'h00C0C, 1'b0, 20'h00C0C, 1'b0, 1'b0);
      lookup(5'd31, 20'hFFFFF, 1'b0, 20'hFFFFF, 1'b0, 1'b0);
      lookup(5'd31, 20'hFFFFF, 1'b0, 20'hFFFFF, 1'b0, 1'b0);

      for (int n = 0; n < 80; n++) begin
         r_idx  = IW'($urandom_range(0, 7));
         r_tag  = TAG_W'($urandom_range(0, 2));
         r_ftag = ($urandom_range(0, 3) == 0) ? TAG_W'($urandom_range(0, 2)) : r_tag;
         lookup(r_idx, r_tag, ($urandom_range(0, 4) == 0), r_ftag,
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
